oled_step_sequencer: RTL and testbench
======================================

# oled_step_sequencer

Parametrised ROM-driven step sequencer for SSD1306-class OLED bring-up and refresh. It fetches 32-bit encoded steps from an external synchronous ROM and executes them in order: pin updates, tick-based waits, SPI command/data bytes, fill bursts and nested loops. Bytes go to an external `spi_master` through a valid/ready/done handshake. Waits use a clock-enable tick, so the whole block runs on the single system clock with no divided clock.

## Interface
- `ADDR_WIDTH`, 8: ROM address width.
- `PIN_COUNT`, 4: number of driven GPIO pins (default order {vdd, vbat, res, spare}).
- `PIN_RESET`, 4'b0011: value of `pins` out of reset.
- `TICK_DIV`, 50000: clk cycles per wait tick (≥1).
- `WAIT_WIDTH`, 24: wait-count width (≤28).
- `LOOP_DEPTH`, 2: loop stack entries (≥1).

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: one-cycle pulse; begins execution at address 0 when IDLE.
- `abort` in 1: returns to IDLE from any state.
- `rom_addr` out ADDR_WIDTH: ROM address (registered).
- `rom_data` in 32: ROM word, valid one cycle after `rom_addr`.
- `tx_valid` out 1: byte request to SPI master.
- `tx_ready` in 1: SPI master accepts byte when high with `tx_valid`.
- `tx_done` in 1: one-cycle pulse when the accepted byte has fully shifted out.
- `tx_byte` out 8: byte to send.
- `oled_dc` out 1: D/C for the current byte (0 = command, 1 = data).
- `pins` out PIN_COUNT: registered GPIO outputs.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: sticky; set on END; cleared by `start`.
- `error` out 1: sticky; set on a fault; cleared by `start`.

## Operation
- Step word: [31:28] opcode, [27:0] arg.
- Opcodes:
  - 0 END: sets `done` and enters DONE.
  - 1 PINS: `pins` <= arg[PIN_COUNT-1:0].
  - 2 WAIT: waits arg[WAIT_WIDTH-1:0] ticks; a count of 0 completes immediately.
  - 3 CMD: sends arg[7:0] with dc=0.
  - 4 DATA: sends arg[7:0] with dc=1.
  - 5 FILL: sends arg[7:0] with dc=1, arg[23:8]+1 times.
  - 6 LOOP: pushes {addr+1, arg[15:0]}; a count of 0 is treated as 1.
  - 7 ENDLOOP: if top count > 1, decrements it and jumps to the top address; otherwise pops and falls through.
  - 8–15: illegal, set `error`.
- States: IDLE, FETCH, DECODE, WAIT, TX_REQ, TX_WAIT, DONE, ERROR.
  - IDLE --start--> FETCH. `rom_addr` <= 0 and the loop stack is cleared.
  - FETCH → DECODE, one cycle for the ROM latency.
  - DECODE, by opcode:
    - PINS / LOOP / ENDLOOP: act, then FETCH at the next address.
    - WAIT: load the counter, then WAIT.
    - CMD / DATA / FILL: load the byte, dc and burst count, then TX_REQ.
    - END: DONE.
    - illegal: ERROR.
  - WAIT: decrements on each tick; at 0 → FETCH at the next address.
  - TX_REQ: `tx_valid`=1 until `tx_ready`, then TX_WAIT with `tx_valid`=0.
  - TX_WAIT: on `tx_done`, if burst count > 0, decrement and go to TX_REQ; otherwise FETCH at the next address.
  - DONE / ERROR: held until `start` (restart) or `abort` (→ IDLE).
- Faults that set `error`:
  - illegal opcode;
  - LOOP when the stack is full;
  - ENDLOOP when the stack is empty;
  - advancing past address 2^ADDR_WIDTH−1 (no wrap).
- `abort`, or `start` while busy:
  - `abort` forces IDLE on the next edge and drops `tx_valid`. `pins`, `done` and `error` are kept.
  - `start` while busy is ignored.
- `tx_byte` and `oled_dc` are held stable from TX_REQ entry until leaving TX_WAIT.

## Timing
- Reset values:
  - `rom_addr`=0, `tx_valid`=0, `tx_byte`=0, `oled_dc`=0;
  - `pins`=PIN_RESET;
  - `busy`=0, `done`=0, `error`=0;
  - state IDLE; tick counter 0; stack empty.
- Step cost:
  - PINS / LOOP / ENDLOOP: 2 cycles (FETCH + DECODE). `pins` changes on the edge that ends DECODE.
  - WAIT n: 2 cycles plus n ticks. The tick prescaler free-runs, so the first tick arrives within 1..TICK_DIV cycles.
  - Byte: 2 cycles + handshake + SPI time.
- `tx_valid` rises on the edge after DECODE.
  - The transfer is accepted on the first edge with `tx_valid` && `tx_ready`.
  - A `tx_done` pulse arriving outside TX_WAIT is ignored.
  - Back-to-back FILL bytes have a 1-cycle gap: `tx_done` → TX_REQ.
- `done` and `error` assert on the edge leaving DECODE (or the faulting edge). `busy` drops on the same edge.
- `start` and `abort` together: `abort` wins.

## Test plan
- Reset mid-TX_WAIT → all outputs at their reset values next cycle; a following `start` runs from address 0 and `pins`=4'b0011 until the first PINS step.
- ROM {PINS 4'hA, WAIT 3, CMD 8'hAE, END}, TICK_DIV=4, `tx_ready`=1, `tx_done` 5 cycles after accept → `pins`=A; 3 ticks elapse; one byte AE with dc=0; `done`=1, `busy`=0.
- FILL 8'h00 with arg[23:8]=1023 → exactly 1024 bytes, all with dc=1; each byte is issued only after the preceding `tx_done`; `tx_valid` is held while `tx_ready` is low.
- Nested LOOP 3 {LOOP 2 {DATA 8'h55} ENDLOOP} ENDLOOP → 6 bytes of 55; LOOP 0 {DATA} ENDLOOP → 1 byte.
- Faults → `error`=1 and the sequencer halts:
  - opcode 9;
  - third nested LOOP with LOOP_DEPTH=2;
  - a stray ENDLOOP;
  - a step at address 255 that is not END.
- `abort` during WAIT → IDLE next cycle with `busy`=0; `start` during busy is ignored; `start` and `abort` in the same cycle leave the block in IDLE.

Source files
------------

// File: rtl/oled_step_sequencer.sv
// ROM-driven step sequencer for SSD1306-class OLED bring-up: pin updates, tick waits,
// SPI command/data bytes, fill bursts and nested loops, all on clk with a tick enable.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_FETCH  | rom_addr presented, ROM latency cycle
// ST_DECODE | rom_data valid, execute or dispatch the step
// ST_WAIT   | counting wait ticks
// ST_TX_REQ | tx_valid high until tx_ready
// ST_TX_WAIT| byte accepted, waiting for tx_done
// ST_DONE   | END reached, held until start/abort
// ST_ERROR  | fault, held until start/abort
module oled_step_sequencer #(
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   PIN_COUNT  = 4,
  parameter logic [PIN_COUNT-1:0] PIN_RESET  = 4'b0011,
  parameter int                   TICK_DIV   = 50000,
  parameter int                   WAIT_WIDTH = 24,
  parameter int                   LOOP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  tx_done,
  output logic [7:0]            tx_byte,
  output logic                  oled_dc,
  output logic [PIN_COUNT-1:0]  pins,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SPW = $clog2(LOOP_DEPTH + 1);
  localparam int STK = 1 << SPW;

  localparam logic [3:0] OP_END     = 4'd0;
  localparam logic [3:0] OP_PINS    = 4'd1;
  localparam logic [3:0] OP_WAIT    = 4'd2;
  localparam logic [3:0] OP_CMD     = 4'd3;
  localparam logic [3:0] OP_DATA    = 4'd4;
  localparam logic [3:0] OP_FILL    = 4'd5;
  localparam logic [3:0] OP_LOOP    = 4'd6;
  localparam logic [3:0] OP_ENDLOOP = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_WAIT, ST_TX_REQ, ST_TX_WAIT, ST_DONE, ST_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  dc_q, dc_d;
  logic [PIN_COUNT-1:0]  pins_q, pins_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic [15:0]           burst_q, burst_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] stk_addr_q [STK];
  logic [ADDR_WIDTH-1:0] stk_addr_d [STK];
  logic [15:0]           stk_cnt_q [STK];
  logic [15:0]           stk_cnt_d [STK];

  logic [3:0]     opcode;
  logic [27:0]    arg;
  logic           tick;
  logic           advance;
  logic           fault;
  logic [SPW-1:0] top;
  logic [15:0]    loop_cnt;
  logic           unused_arg;

  assign opcode     = rom_data[31:28];
  assign arg        = rom_data[27:0];
  assign tick       = (presc_q == '0);
  assign top        = sp_q - SPW'(1);
  assign loop_cnt   = (arg[15:0] == 16'd0) ? 16'd1 : arg[15:0];
  assign unused_arg = ^arg[27:24];

  assign rom_addr = rom_addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;
  assign oled_dc  = dc_q;
  assign pins     = pins_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    dc_d       = dc_q;
    pins_d     = pins_q;
    done_d     = done_q;
    error_d    = error_q;
    wait_d     = wait_q;
    burst_d    = burst_q;
    sp_d       = sp_q;
    stk_addr_d = stk_addr_q;
    stk_cnt_d  = stk_cnt_q;
    advance    = 1'b0;
    fault      = 1'b0;
    // prescaler free-runs so tick phase is independent of when a WAIT starts
    presc_d    = tick ? PW'(TICK_DIV - 1) : presc_q - PW'(1);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_FETCH;
          rom_addr_d = '0;
          sp_d       = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_END: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
          OP_PINS: begin
            pins_d  = arg[PIN_COUNT-1:0];
            advance = 1'b1;
          end
          OP_WAIT: begin
            if (arg[WAIT_WIDTH-1:0] == '0) begin
              advance = 1'b1;
            end else begin
              wait_d  = arg[WAIT_WIDTH-1:0];
              state_d = ST_WAIT;
            end
          end
          OP_CMD, OP_DATA, OP_FILL: begin
            tx_byte_d  = arg[7:0];
            dc_d       = (opcode != OP_CMD);
            burst_d    = (opcode == OP_FILL) ? arg[23:8] : 16'd0;
            tx_valid_d = 1'b1;
            state_d    = ST_TX_REQ;
          end
          OP_LOOP: begin
            if (sp_q == SPW'(LOOP_DEPTH)) begin
              fault = 1'b1;
            end else begin
              stk_addr_d[sp_q] = rom_addr_q + ADDR_WIDTH'(1);
              stk_cnt_d[sp_q]  = loop_cnt;
              sp_d             = sp_q + SPW'(1);
              advance          = 1'b1;
            end
          end
          OP_ENDLOOP: begin
            if (sp_q == '0) begin
              fault = 1'b1;
            end else if (stk_cnt_q[top] > 16'd1) begin
              stk_cnt_d[top] = stk_cnt_q[top] - 16'd1;
              rom_addr_d     = stk_addr_q[top];
              state_d        = ST_FETCH;
            end else begin
              sp_d    = top;
              advance = 1'b1;
            end
          end
          default: fault = 1'b1;
        endcase
      end
      ST_WAIT: begin
        if (tick) begin
          if (wait_q == WAIT_WIDTH'(1)) advance = 1'b1;
          else wait_d = wait_q - WAIT_WIDTH'(1);
        end
      end
      ST_TX_REQ: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (tx_done) begin
          if (burst_q != 16'd0) begin
            burst_d    = burst_q - 16'd1;
            tx_valid_d = 1'b1;
            state_d    = ST_TX_REQ;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // the address space does not wrap: stepping off the last word is a fault
    if (advance) begin
      if (&rom_addr_q) begin
        fault = 1'b1;
      end else begin
        rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
        state_d    = ST_FETCH;
      end
    end

    if (fault) begin
      state_d = ST_ERROR;
      error_d = 1'b1;
    end

    if (abort) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      pins_d     = pins_q;
      done_d     = done_q;
      error_d    = error_q;
    end

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'd0;
      dc_q       <= 1'b0;
      pins_q     <= PIN_RESET;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      presc_q    <= '0;
      wait_q     <= '0;
      burst_q    <= 16'd0;
      sp_q       <= '0;
      stk_addr_q <= '{default: '0};
      stk_cnt_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      dc_q       <= dc_d;
      pins_q     <= pins_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      presc_q    <= presc_d;
      wait_q     <= wait_d;
      burst_q    <= burst_d;
      sp_q       <= sp_d;
      stk_addr_q <= stk_addr_d;
      stk_cnt_q  <= stk_cnt_d;
    end
  end

endmodule

// File: tb/tb_oled_step_sequencer.sv
// Bench for oled_step_sequencer: vector table, corner-case sequences and random
// programs checked against a step-interpreter model of the sequencer.
module tb_oled_step_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_byte;
  logic        oled_dc;
  logic [3:0]  pins;
  logic        busy, done, error;

  oled_step_sequencer #(
    .ADDR_WIDTH(8), .PIN_COUNT(4), .PIN_RESET(4'b0011),
    .TICK_DIV(TD), .WAIT_WIDTH(24), .LOOP_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
    .tx_byte(tx_byte), .oled_dc(oled_dc), .pins(pins),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad = 0;

  // SPI master stand-in, driven on the falling edge
  bit         rdy_random = 1'b0;
  int         done_delay = 5;
  logic [8:0] cap[$];
  int         proto_bad = 0;
  bit         pend = 1'b0;
  bit         outstanding = 1'b0;
  bit         hold = 1'b0;
  int         dcnt = 0;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      pend = 1'b0; outstanding = 1'b0; dcnt = 0; hold = 1'b0;
    end else begin
      if (pend) begin
        cap.push_back({oled_dc, tx_byte});
        if (outstanding) proto_bad++;
        outstanding = 1'b1;
        dcnt = done_delay;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          tx_done = 1'b1;
          outstanding = 1'b0;
        end
      end
      if (hold && !tx_valid) proto_bad++;
    end
    tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    hold = tx_valid && !tx_ready;
    pend = tx_valid && tx_ready && !rst;
  end

  function automatic logic [31:0] st(input logic [3:0] op, input logic [27:0] a);
    return {op, a};
  endfunction

  function automatic logic [7:0][31:0] p8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc(1);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL run_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
    end
    cyc(2);
  endtask

  task automatic run_prog(input int budget);
    cap.delete();
    pulse_start();
    wait_idle(budget);
  endtask

  // Reference: interpret the ROM program step by step at the language level
  logic [8:0] exp_q[$];
  logic [3:0] exp_pins;
  bit         exp_done, exp_err;

  task automatic model_run();
    int pc, guard;
    int sa[$];
    int sc[$];
    logic [31:0] w;
    bit adv;
    exp_q.delete();
    exp_pins = 4'b0011; exp_done = 1'b0; exp_err = 1'b0;
    pc = 0; guard = 0;
    while (guard < 5000) begin
      guard++;
      w = rom[pc];
      adv = 1'b1;
      case (w[31:28])
        4'd0: begin exp_done = 1'b1; return; end
        4'd1: exp_pins = w[3:0];
        4'd2: ;
        4'd3: exp_q.push_back({1'b0, w[7:0]});
        4'd4: exp_q.push_back({1'b1, w[7:0]});
        4'd5: for (int k = 0; k <= int'(w[23:8]); k++) exp_q.push_back({1'b1, w[7:0]});
        4'd6: begin
          if (sa.size() == 2) begin exp_err = 1'b1; return; end
          sa.push_back(pc + 1);
          sc.push_back((w[15:0] == 16'd0) ? 1 : int'(w[15:0]));
        end
        4'd7: begin
          if (sa.size() == 0) begin exp_err = 1'b1; return; end
          if (sc[sc.size()-1] > 1) begin
            sc[sc.size()-1] = sc[sc.size()-1] - 1;
            pc = sa[sa.size()-1];
            adv = 1'b0;
          end else begin
            void'(sa.pop_back());
            void'(sc.pop_back());
          end
        end
        default: begin exp_err = 1'b1; return; end
      endcase
      if (adv) begin
        if (pc == 255) begin exp_err = 1'b1; return; end
        pc++;
      end
    end
  endtask

  typedef struct {
    string            name;
    logic [7:0][31:0] prog;
    int               nb;
    logic [8:0]       b;
    logic [3:0]       pins;
    logic             dn;
    logic             er;
  } vec_t;

  vec_t vt[8];

  task automatic set_vec(input int i, input string nm, input logic [7:0][31:0] pr, input int nb,
                         input logic [8:0] b, input logic [3:0] pn, input logic dn, input logic er);
    vt[i].name = nm; vt[i].prog = pr; vt[i].nb = nb; vt[i].b = b;
    vt[i].pins = pn; vt[i].dn = dn; vt[i].er = er;
  endtask

  initial begin
    int n, nmis, r;

    set_vec(0, "basic", p8(st(1, 28'hA), st(2, 28'd3), st(3, 28'hAE), 0, 0, 0, 0, 0),
            1, 9'h0AE, 4'hA, 1'b1, 1'b0);
    set_vec(1, "nested", p8(st(6, 28'd3), st(6, 28'd2), st(4, 28'h55), st(7, 0), st(7, 0), 0, 0, 0),
            6, 9'h155, 4'h3, 1'b1, 1'b0);
    set_vec(2, "loop0", p8(st(6, 28'd0), st(4, 28'h77), st(7, 0), 0, 0, 0, 0, 0),
            1, 9'h177, 4'h3, 1'b1, 1'b0);
    set_vec(3, "illegal9", p8(st(1, 28'h5), st(9, 28'h123), st(3, 28'h11), 0, 0, 0, 0, 0),
            0, 9'h000, 4'h5, 1'b0, 1'b1);
    set_vec(4, "stack_full", p8(st(6, 28'd1), st(6, 28'd1), st(6, 28'd1), st(4, 28'h01), 0, 0, 0, 0),
            0, 9'h000, 4'h3, 1'b0, 1'b1);
    set_vec(5, "stray_endloop", p8(st(3, 28'h12), st(7, 0), st(3, 28'h13), 0, 0, 0, 0, 0),
            1, 9'h012, 4'h3, 1'b0, 1'b1);
    set_vec(6, "fill3", p8(st(5, {4'h0, 16'd2, 8'hC3}), 0, 0, 0, 0, 0, 0, 0),
            3, 9'h1C3, 4'h3, 1'b1, 1'b0);
    set_vec(7, "wait0", p8(st(2, 28'd0), st(4, 28'h9A), st(1, 28'hF), 0, 0, 0, 0, 0),
            1, 9'h19A, 4'hF, 1'b1, 1'b0);

    clear_rom();
    cyc(1);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_dc", oled_dc, 0);
    chk("rst_pins", pins, 4'b0011);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    cyc(2);

    // vector table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      clear_rom();
      for (int k = 0; k < 8; k++) rom[k] = vt[i].prog[k];
      rdy_random = 1'b0; done_delay = 3; proto_bad = 0;
      run_prog(2000);
      chk({vt[i].name, "_nbytes"}, cap.size(), vt[i].nb);
      nmis = 0;
      foreach (cap[k]) if (cap[k] !== vt[i].b) nmis++;
      chk({vt[i].name, "_bytes"}, nmis, 0);
      chk({vt[i].name, "_pins"}, pins, vt[i].pins);
      chk({vt[i].name, "_done"}, done, vt[i].dn);
      chk({vt[i].name, "_error"}, error, vt[i].er);
      chk({vt[i].name, "_busy"}, busy, 0);
      chk({vt[i].name, "_proto"}, proto_bad, 0);
    end

    // latency of PINS + WAIT 3 ticks + CMD decode up to tx_valid
    do_reset();
    clear_rom();
    for (int k = 0; k < 8; k++) rom[k] = vt[0].prog[k];
    rdy_random = 1'b0; done_delay = 5;
    cap.delete();
    pulse_start();
    n = 0;
    while (!tx_valid && n < 40) begin
      cyc(1);
      n++;
    end
    total++;
    if (n < 15 || n > 18) begin
      bad++;
      $display("FAIL wait_latency: tx_valid after %0d edges, required 15..18", n);
    end
    wait_idle(200);
    chk("latency_done", done, 1);

    // reset mid-TX_WAIT, then restart from address 0
    do_reset();
    clear_rom();
    rom[0] = st(1, 28'h5); rom[1] = st(3, 28'h11);
    done_delay = 50;
    cap.delete();
    pulse_start();
    n = 0;
    while (cap.size() == 0 && n < 50) begin cyc(1); n++; end
    chk("midtx_accepted", cap.size(), 1);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("midtx_rom_addr", rom_addr, 0);
    chk("midtx_tx_valid", tx_valid, 0);
    chk("midtx_tx_byte", tx_byte, 0);
    chk("midtx_dc", oled_dc, 0);
    chk("midtx_pins", pins, 4'b0011);
    chk("midtx_busy", busy, 0);
    chk("midtx_done", done, 0);
    chk("midtx_error", error, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    clear_rom();
    rom[0] = st(2, 28'd2); rom[1] = st(1, 28'h6);
    done_delay = 5;
    cap.delete();
    pulse_start();
    cyc(3);
    chk("restart_pins_before", pins, 4'b0011);
    wait_idle(200);
    chk("restart_pins_after", pins, 4'h6);
    chk("restart_done", done, 1);
    chk("restart_nbytes", cap.size(), 0);

    // 1024-byte fill under random back-pressure
    do_reset();
    clear_rom();
    rom[0] = st(5, {4'h0, 16'd1023, 8'h00});
    rdy_random = 1'b1; done_delay = 1; proto_bad = 0;
    run_prog(20000);
    chk("fill_nbytes", cap.size(), 1024);
    nmis = 0;
    foreach (cap[k]) if (cap[k] !== 9'h100) nmis++;
    chk("fill_bytes", nmis, 0);
    chk("fill_proto", proto_bad, 0);
    chk("fill_done", done, 1);
    rdy_random = 1'b0;

    // top-of-ROM fault, then the same address holding END
    do_reset();
    for (int i = 0; i < 255; i++) rom[i] = st(1, 28'h1);
    rom[255] = st(1, 28'h5);
    run_prog(1000);
    chk("addr255_error", error, 1);
    chk("addr255_pins", pins, 4'h5);
    chk("addr255_busy", busy, 0);
    rom[255] = 32'h0;
    run_prog(1000);
    chk("addr255_end_error", error, 0);
    chk("addr255_end_done", done, 1);

    // abort during WAIT
    do_reset();
    clear_rom();
    rom[0] = st(1, 28'h9); rom[1] = st(2, 28'd100); rom[2] = st(3, 28'h44);
    cap.delete();
    pulse_start();
    cyc(10);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pins", pins, 4'h9);
    chk("abort_done", done, 0);
    cyc(20);
    chk("abort_stays_idle", busy, 0);
    chk("abort_nbytes", cap.size(), 0);

    // start while busy is ignored
    clear_rom();
    rom[0] = st(3, 28'h33); rom[1] = st(2, 28'd5);
    cap.delete();
    done_delay = 5;
    pulse_start();
    n = 0;
    while (cap.size() == 0 && n < 50) begin cyc(1); n++; end
    cyc(12);
    pulse_start();
    wait_idle(300);
    chk("busy_start_nbytes", cap.size(), 1);
    chk("busy_start_done", done, 1);

    // start and abort together: abort wins, from DONE and from busy
    start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    cyc(10);
    chk("both_done_busy", busy, 0);
    chk("both_done_kept", done, 1);
    chk("both_done_nbytes", cap.size(), 1);
    clear_rom();
    rom[0] = st(2, 28'd50);
    pulse_start();
    cyc(5);
    start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    chk("both_busy_busy", busy, 0);
    cyc(10);
    chk("both_busy_idle", busy, 0);
    chk("both_busy_done", done, 0);

    // random programs against the interpreter model
    for (int t = 0; t < 30; t++) begin
      do_reset();
      clear_rom();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 99);
        if (r < 12)      rom[i] = st(4'd1, 28'($urandom));
        else if (r < 22) rom[i] = st(4'd2, 28'($urandom_range(0, 2)));
        else if (r < 40) rom[i] = st(4'd3, 28'($urandom));
        else if (r < 55) rom[i] = st(4'd4, 28'($urandom));
        else if (r < 65) rom[i] = st(4'd5, {4'($urandom), 16'($urandom_range(0, 3)), 8'($urandom)});
        else if (r < 77) rom[i] = st(4'd6, {12'($urandom), 16'($urandom_range(0, 3))});
        else if (r < 92) rom[i] = st(4'd7, 28'($urandom));
        else if (r < 95) rom[i] = {4'($urandom_range(8, 15)), 28'($urandom)};
        else             rom[i] = 32'h0;
      end
      rdy_random = 1'($urandom_range(0, 1));
      done_delay = $urandom_range(1, 4);
      proto_bad = 0;
      model_run();
      run_prog(20000);
      chk($sformatf("rnd%0d_nbytes", t), cap.size(), exp_q.size());
      nmis = 0;
      foreach (cap[k]) if (k < exp_q.size() && cap[k] !== exp_q[k]) nmis++;
      chk($sformatf("rnd%0d_bytes", t), nmis, 0);
      chk($sformatf("rnd%0d_pins", t), pins, exp_pins);
      chk($sformatf("rnd%0d_done", t), done, exp_done);
      chk($sformatf("rnd%0d_error", t), error, exp_err);
      chk($sformatf("rnd%0d_proto", t), proto_bad, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
